// File: rtl/cs_pkg.sv
// cs_pkg: shared types and bit-manipulation helpers for the cyclic-shift encoder
package cs_pkg;
  typedef enum logic [1:0] {COLLECT, PARITY, DROP} state_t;
  function automatic logic [63:0] lift(input logic [63:0] x, input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return (x & m) | (64'(^(x & m)) << w);
  endfunction
  // Widths up to 32 keep the double-width shift inside 64 bits.
  function automatic logic [63:0] rotl(input logic [63:0] v, input int s, input int w);
    logic [63:0] m, vm;
    m = (64'd1 << w) - 64'd1;
    vm = v & m;
    return ((vm << s) | (vm >> (w - s))) & m;
  endfunction
  function automatic bit steps_ok(input logic [255:0] steps, input int m, input int w);
    for (int r = 0; r < m; r++) if (int'(steps[r*8+:8]) >= w) return 1'b0;
    return 1'b1;
  endfunction
endpackage

// File: rtl/cs_parity_lane.sv
// cs_parity_lane: one parity row accumulator with its running rotation amount
module cs_parity_lane
  import cs_pkg::*;
#(
  parameter int LOUT = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [LOUT-1:0] sym,
  input  logic [7:0]      step,
  output logic [LOUT-1:0] acc
);
  logic [LOUT-1:0] acc_q;
  logic [7:0] rot_q, rot_d;
  logic [8:0] sum;
  assign sum = {1'b0, rot_q} + {1'b0, step};
  assign rot_d = sum >= 9'(LOUT) ? 8'(sum - 9'(LOUT)) : sum[7:0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      rot_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
      rot_q <= '0;
    end else if (en) begin
      acc_q <= acc_q ^ LOUT'(rotl(64'(sym), int'(rot_q), LOUT));
      rot_q <= rot_d;
    end
  end
  assign acc = acc_q;
endmodule

// File: rtl/cs_encoder_kxm.sv
// cs_encoder_kxm: systematic K+M cyclic-shift encoder with registered AXI-Stream output
module cs_encoder_kxm
  import cs_pkg::*;
#(
  parameter int             LIN      = 11,
  parameter int             K        = 3,
  parameter int             M        = 2,
  parameter logic [M*8-1:0] ROT_STEP = {8'd5, 8'd1}
) (
  input  logic           aclk,
  input  logic           areset,
  input  logic [LIN-1:0] s_axis_tdata,
  input  logic           s_axis_tvalid,
  output logic           s_axis_tready,
  input  logic           s_axis_tlast,
  output logic [LIN:0]   m_axis_tdata,
  output logic           m_axis_tvalid,
  input  logic           m_axis_tready,
  output logic           m_axis_tlast,
  output logic           err_short,
  output logic           err_long
);
  localparam int LOUT = LIN + 1;
  localparam int CW = $clog2(K + 1);
  localparam int PW = $clog2(M + 1);
  if (!steps_ok(256'(ROT_STEP), M, LOUT) || K < 2 || K > 16 || M < 1 || M > 8 || LOUT > 32) begin : g_bad
    $error("cs_encoder_kxm: parameter out of range");
  end
  state_t state_q, state_d;
  logic [CW-1:0] in_cnt_q;
  logic [PW-1:0] par_q;
  logic drop_q, valid_q, last_q, err_s_q, err_l_q;
  logic [LOUT-1:0] data_q, lifted, par_sym;
  logic [LOUT-1:0] acc [M];
  logic s_ready, s_fire, m_fire, out_free, col_fire, at_k, close, load_par, frame_done;
  assign lifted = LOUT'(lift(64'(s_axis_tdata), LIN));
  for (genvar r = 0; r < M; r++) begin : g_lane
    cs_parity_lane #(.LOUT(LOUT)) u_lane (
      .clk (aclk),
      .rst (areset),
      .clr (frame_done),
      .en  (col_fire),
      .sym (lifted),
      .step(ROT_STEP[r*8+:8]),
      .acc (acc[r])
    );
  end
  always_comb begin
    par_sym = '0;
    for (int r = 0; r < M; r++) if (par_q == PW'(r)) par_sym = acc[r];
  end
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= COLLECT;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == COLLECT ? (close ? PARITY : COLLECT)
            : state_q == PARITY  ? (frame_done ? (drop_q ? DROP : COLLECT) : PARITY)
            : (s_fire && s_axis_tlast ? COLLECT : DROP);
  end
  always_comb begin
    out_free   = !valid_q || m_axis_tready;
    m_fire     = valid_q && m_axis_tready;
    s_ready    = state_q == COLLECT ? out_free : state_q == DROP;
    s_fire     = s_axis_tvalid && s_ready;
    col_fire   = s_fire && state_q == COLLECT;
    at_k       = in_cnt_q == CW'(K - 1);
    close      = col_fire && (s_axis_tlast || at_k);
    load_par   = state_q == PARITY && out_free && par_q < PW'(M);
    frame_done = state_q == PARITY && m_fire && last_q;
  end
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      in_cnt_q <= '0;
      par_q    <= '0;
      drop_q   <= 1'b0;
      err_s_q  <= 1'b0;
      err_l_q  <= 1'b0;
    end else begin
      if (col_fire) begin
        data_q  <= lifted;
        valid_q <= 1'b1;
        last_q  <= 1'b0;
      end else if (load_par) begin
        data_q  <= par_sym;
        valid_q <= 1'b1;
        last_q  <= par_q == PW'(M - 1);
      end else if (m_fire) begin
        valid_q <= 1'b0;
      end
      in_cnt_q <= frame_done ? '0 : col_fire ? in_cnt_q + 1'b1 : in_cnt_q;
      par_q    <= frame_done ? '0 : load_par ? par_q + 1'b1 : par_q;
      drop_q   <= col_fire && at_k && !s_axis_tlast ? 1'b1
                : state_q == DROP && s_fire && s_axis_tlast ? 1'b0 : drop_q;
      err_s_q  <= col_fire && s_axis_tlast && !at_k;
      err_l_q  <= col_fire && at_k && !s_axis_tlast;
    end
  end
  assign s_axis_tready = s_ready;
  assign m_axis_tdata  = data_q;
  assign m_axis_tvalid = valid_q;
  assign m_axis_tlast  = last_q;
  assign err_short     = err_s_q;
  assign err_long      = err_l_q;
endmodule

// File: doc/cs_encoder_kxm.md
# cs_encoder_kxm

Parametrised cyclic-shift systematic encoder for the CSNC transmit path, feeding the channel framer.
- Accepts frames of K information symbols of LIN bits on AXI-Stream.
- Lifts each symbol to LOUT = LIN+1 bits by prepending its even-parity bit.
- Forwards the lifted symbols unchanged, then appends M parity symbols. Each parity symbol is an XOR of cyclically rotated lifted symbols.
- Adds three things to the fixed 3+2 encoder: a fully registered output, frame-length error handling, and arbitrary K/M with per-row rotation steps.

## Interface
Parameters:
- LIN, 11, input symbol width; LOUT = LIN+1 is a localparam.
- K, 3, information symbols per frame, 2..16.
- M, 2, parity symbols per frame, 1..8.
- ROT_STEP, {8'd5, 8'd1}, packed M×8 vector; entry r is the rotation step of parity row r; each entry < LOUT.

Ports:
- aclk, in, 1, clock.
- areset, in, 1, reset. One clock; reset is asynchronous and active-high.
- s_axis_tdata, in, LIN, information symbol.
- s_axis_tvalid, in, 1, input valid.
- s_axis_tready, out, 1, input ready.
- s_axis_tlast, in, 1, last information symbol of the frame.
- m_axis_tdata, out, LOUT, lifted info or parity symbol.
- m_axis_tvalid, out, 1, output valid.
- m_axis_tready, in, 1, output ready.
- m_axis_tlast, out, 1, asserted on parity symbol M-1.
- err_short, out, 1, one-cycle pulse when tlast arrives before symbol K.
- err_long, out, 1, one-cycle pulse when symbol K is accepted without tlast.

## Operation
- Lift: lift(x) = {^x, x}.
- Rotation: rotl(v,s) is a left cyclic rotation over LOUT bits.
- Parity row r: P_r = XOR over k of rotl(lift(x_k), (k·ROT_STEP[r]) mod LOUT).
  - Each row tracks its own rotation amount rot_r, with no multiplier.
  - rot_r resets to 0 at the start of every frame.
  - After each accepted symbol, rot_r += ROT_STEP[r]; if the result is ≥ LOUT, subtract LOUT.
- State COLLECT (reset state):
  - Each accepted symbol is loaded, lifted, into the output register.
  - acc_r ^= rotl(lift(x), rot_r) for every row.
  - in_cnt increments on each accepted symbol.
  - tlast accepted with in_cnt+1 < K: err_short pulses, go to PARITY. Missing symbols count as zero, so the output frame has in_cnt+1+M symbols.
  - tlast accepted with in_cnt+1 == K: go to PARITY.
  - Symbol K accepted without tlast: err_long pulses, drop_pend is set, go to PARITY.
- State PARITY:
  - s_axis_tready = 0.
  - Parity rows 0..M-1 are loaded in order into the output register as it frees.
  - On acceptance of row M-1 (tlast=1): clear all acc_r, rot_r and in_cnt; go to DROP if drop_pend, else to COLLECT.
- State DROP:
  - s_axis_tready = 1; input symbols are discarded, with no output and no accumulation.
  - When tlast is accepted: clear drop_pend, go to COLLECT.
- Info symbols always carry m_axis_tlast = 0.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, err_short=0, err_long=0, state=COLLECT, all accumulators and counters 0.
- Reset is honoured mid-frame: a partial frame is abandoned and nothing is emitted.
- Output register:
  - m_axis_* come straight from flops; there is no combinational path from s_axis to m_axis.
  - It loads when empty or when being drained in the same cycle (tvalid && tready).
- s_axis_tready:
  - COLLECT: = !m_axis_tvalid || m_axis_tready.
  - PARITY: 0.
  - DROP: 1.
- Latency: an accepted info symbol appears on m_axis the next cycle.
- Parity throughput:
  - Parity row 0 is valid the cycle after the last info symbol is accepted, provided that info symbol is drained that cycle.
  - Under continuous m_axis_tready: one symbol per cycle, no bubble between info and parity.
  - The next frame's first symbol can be accepted in the cycle after parity M-1 drains.
- Backpressure: while m_axis_tvalid=1 and tready=0, m_axis_tdata and tlast are held stable.
- err_short/err_long assert in the cycle after the offending input handshake.

## Structure
- Shared package cs_pkg holds:
  - the state_t enum (COLLECT, PARITY, DROP);
  - functions lift and rotl, parametrised by width;
  - a helper that checks ROT_STEP < LOUT, used by an elaboration-time assertion.
- Sub-module cs_parity_lane, instantiated M times via generate. Each lane holds one LOUT accumulator plus its rot_r counter, with inputs clr, en, sym and step. The top level holds the FSM, the counters and the output register.

## Test plan
- Defaults; input 0x001 three times (tlast on the third), tready=1. Expect outputs 0x801, 0x801, 0x801, 0x804, 0xE31, with tlast only on 0xE31; back-to-back cycles with no bubbles.
- Defaults; inputs 0x000, 0x001, 0x000. Expect parity 0x003, 0x030. Then inputs 0x000, 0x000, 0x001. Expect parity 0x006, 0x600.
- Short frame: input 0x001 with tlast on the first symbol. Expect err_short pulse; output 0x801, 0x801, 0x801 with tlast on the last; next frame encodes correctly.
- Long frame: input 0x001 five times, tlast on the fifth. Expect err_long after the third; output identical to test 1; symbols 4 and 5 dropped with tready=1; next frame correct.
- Random m_axis_tready and s_axis_tvalid over 1000 frames with K=5, M=4, random ROT_STEP; check against the golden model. Data must stay stable under stall, tready must be 0 in PARITY, and no symbols may be lost.
- Assert areset mid-parity. Expect m_axis_tvalid to fall asynchronously; the following frame produces correct parity with no residue from the old accumulators.
